// File: rtl/input_conditioner_if.sv
// Signal bundle between the raw pad inputs, the VGA frame strobe and the
// conditioned outputs consumed by the pause/resume/speed logic.
//
// Transfer semantics: there is no valid/ready pairing. raw_in is a free-running
// level sampled every clock; frame_start, rise, pause_pulse, resume_pulse and
// speed_changed are single-cycle strobes that are meaningful on every clock and
// cannot be back-pressured; level and speed are held levels.
interface input_conditioner_if;
  logic [7:0] raw_in;
  logic       frame_start;
  logic [7:0] level;
  logic [7:0] rise;
  logic       pause_pulse;
  logic       resume_pulse;
  logic [2:0] speed;
  logic       speed_changed;

  // Producer side: drives pads and frame strobe, observes conditioned outputs.
  modport master (
    output raw_in,
    output frame_start,
    input  level,
    input  rise,
    input  pause_pulse,
    input  resume_pulse,
    input  speed,
    input  speed_changed
  );

  // Conditioner side.
  modport slave (
    input  raw_in,
    input  frame_start,
    output level,
    output rise,
    output pause_pulse,
    output resume_pulse,
    output speed,
    output speed_changed
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises and debounces eight pad inputs, produces rising-edge strobes,
// pause/resume request pulses, and a speed code latched only at frame starts
// so the pattern stepping never changes mid-frame.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input logic                 clk,
  input logic                 rst_n,
  input_conditioner_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [7:0]    s1;
  logic [7:0]    s2;
  logic [CW-1:0] cnt [8];
  logic [7:0]    level_q;
  logic [7:0]    rise_q;
  logic          pause_q;
  logic          resume_q;
  logic [2:0]    speed_q;
  logic          changed_q;

  logic [7:0]    flip;
  logic [7:0]    level_d;
  logic [7:0]    rise_d;
  logic [2:0]    speed_enc;

  // Two-flop synchroniser for every pad bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.raw_in;
      s2 <= s1;
    end
  end

  // A bit flips once it has disagreed with its level for the full count;
  // only 0->1 flips produce an edge strobe.
  always_comb begin
    flip = '0;
    for (int i = 0; i < 8; i++) begin
      flip[i] = (s2[i] != level_q[i]) && (cnt[i] == CNT_MAX);
    end
    level_d = level_q ^ flip;
    rise_d  = flip & s2;
  end

  // Per-bit disagreement counters; any cycle of agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (s2[i] == level_q[i] || flip[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Debounced levels and their registered edge strobes; pause beats resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q  <= '0;
      rise_q   <= '0;
      pause_q  <= 1'b0;
      resume_q <= 1'b0;
    end else begin
      level_q  <= level_d;
      rise_q   <= rise_d;
      pause_q  <= rise_d[0];
      resume_q <= rise_d[1] & ~rise_d[0];
    end
  end

  // Priority encode of the speed switches from the debounced levels.
  always_comb begin
    speed_enc = 3'd1;
    if (level_q[7])      speed_enc = 3'd6;
    else if (level_q[6]) speed_enc = 3'd5;
    else if (level_q[5]) speed_enc = 3'd4;
    else if (level_q[4]) speed_enc = 3'd3;
    else if (level_q[3]) speed_enc = 3'd2;
  end

  // Speed is only sampled on frame_start, using the level held before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_q   <= 3'd1;
      changed_q <= 1'b0;
    end else if (bus.frame_start) begin
      speed_q   <= speed_enc;
      changed_q <= (speed_enc != speed_q);
    end else begin
      changed_q <= 1'b0;
    end
  end

  assign bus.level         = level_q;
  assign bus.rise          = rise_q;
  assign bus.pause_pulse   = pause_q;
  assign bus.resume_pulse  = resume_q;
  assign bus.speed         = speed_q;
  assign bus.speed_changed = changed_q;

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage between the raw `ui_in` pads and the pause/resume/speed logic. It synchronises and debounces all eight pushbutton/switch inputs, generates single-cycle press strobes for pause and resume, and priority-encodes the speed switches. The speed value is latched only at frame boundaries, so the pattern stepping never changes mid-frame.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 50000, consecutive cycles a synchronised input must differ from its debounced level before the level flips. Minimum 2. The counter width is `$clog2(DEBOUNCE_CYCLES)`.

Ports:
- `clk`  in  1  pixel clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `raw_in`  in  8  unsynchronised `ui_in` pads (bit0 pause, bit1 resume, bits3..7 speed_2..speed_6, bit2 unused but conditioned)
- `frame_start`  in  1  single-cycle strobe from VGA timing at the start of vertical blanking
- `level`  out  8  debounced levels
- `rise`  out  8  one-cycle strobe per bit on a debounced 0→1 transition
- `pause_pulse`  out  1  one-cycle pause request
- `resume_pulse`  out  1  one-cycle resume request
- `speed`  out  3  frame-latched speed code, 1..6
- `speed_changed`  out  1  one-cycle strobe when `speed` takes a new value

## Operation
- Reset values: `level`=0, `rise`=0, `pause_pulse`=0, `resume_pulse`=0, `speed`=3'd1, `speed_changed`=0. All synchroniser flops and debounce counters clear to 0.
- Synchroniser: two flops per bit, `s1<=raw_in`, `s2<=s1`.
- Debounce, per bit, with an independent counter `cnt[i]`:
  - If `s2[i]==level[i]`: `cnt[i]<=0`.
  - Else if `cnt[i]==DEBOUNCE_CYCLES-1`: `level[i]<=s2[i]` and `cnt[i]<=0`.
  - Else `cnt[i]<=cnt[i]+1`.
  - Any single cycle of agreement restarts the count, so a bouncing input produces no output change.
- Edges:
  - `rise[i]` is registered and is high only in the first cycle that `level[i]` reads 1.
  - There is no falling-edge strobe.
- Strobes:
  - `pause_pulse = rise[0]`, registered as part of the same edge logic.
  - `resume_pulse = rise[1] & ~rise[0]`: pause wins if both rise in the same cycle.
- Speed encode, combinational from `level`: bit7→6, bit6→5, bit5→4, bit4→3, bit3→2, otherwise 1. The highest set bit wins.
- Speed latch, on a cycle where `frame_start`=1:
  - `speed` is loaded with the encoded value.
  - `speed_changed`=1 for that cycle's successor only if the new value differs from the old one.
  - Between strobes, `speed` holds regardless of `level`.
- Reset mid-operation: asynchronous clear of all state. A press partially debounced before reset has no effect after release; it must complete a full debounce again.

## Timing
- Raw-to-level latency: the new value is first captured by `s1` at edge k, and `level` changes after edge k+DEBOUNCE_CYCLES+1. That is DEBOUNCE_CYCLES+2 edges in total, or 6 edges for DEBOUNCE_CYCLES=4.
- `rise`, `pause_pulse` and `resume_pulse` assert in the same cycle that `level` changes, for exactly 1 cycle.
- `frame_start` at edge f updates `speed` after edge f. `speed_changed` is high for the cycle following edge f.
- If `level` changes on the same edge as `frame_start`, the pre-change encoded value is latched. The new value takes effect at the next `frame_start`.
- Holding an input high produces no repeated strobes.
- Throughput: one debounced transition per bit per DEBOUNCE_CYCLES+1 cycles at most.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: hold `rst_n`=0 with `raw_in`=8'hFF and toggle `frame_start` → all outputs are at their reset values and `speed`=1. After release with `raw_in`=0, outputs are unchanged for 20 cycles.
- Clean press: `raw_in[0]` goes 0→1 before edge k and is held → `level[0]`=1 after edge k+5. `pause_pulse` and `rise[0]` are high for exactly one cycle. Releasing gives `level[0]`=0 six edges later, with no strobes.
- Bounce: toggle `raw_in[1]` every 2 cycles for 20 cycles, then hold at 1 → `level[1]` stays 0 throughout the bouncing and rises 6 edges after the final hold begins. Exactly one `resume_pulse` is produced.
- Speed latch: set `raw_in[7]` and `raw_in[3]` and wait for debounce → `speed` stays 1. On `frame_start`, `speed`=6 next cycle with one `speed_changed` strobe. A second `frame_start` with the same inputs gives no strobe and `speed` stays 6.
- Simultaneous pause/resume: raise `raw_in[0]` and `raw_in[1]` in the same cycle → one `pause_pulse`, `resume_pulse` never asserts, and `rise`=8'b0000_0011 for one cycle.
- Reset mid-debounce: raise `raw_in[0]` and assert `rst_n`=0 for 1 cycle while the counter is at 2 → after release, `level[0]` rises only after a full 6-edge latency from the first post-reset capture.
